// File: rtl/pe_feeder_if.sv
// Bundles the job control, operand-memory read and PE FIFO write signals of pe_feeder.
// master = the feeder itself, slave = the surrounding memories / PE / controller.
interface pe_feeder_if #(
    parameter int DW = 16,
    parameter int AW = 8
);
    logic                 go;
    logic [AW-1:0]        vec_len;
    logic                 hold;
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic signed [DW-1:0] a_rdata;
    logic signed [DW-1:0] b_rdata;
    logic signed [DW-1:0] a_in;
    logic signed [DW-1:0] b_in;
    logic                 awe;
    logic                 bwe;
    logic                 aff;
    logic                 bff;
    logic                 ais;
    logic                 bis;
    logic                 start;
    logic [AW-1:0]        max_cntr;
    logic                 busy;
    logic                 done;

    modport master (
        input  go, vec_len, hold, a_rdata, b_rdata, aff, bff,
        output rd_en, rd_addr, a_in, b_in, awe, bwe, ais, bis, start, max_cntr, busy, done
    );

    modport slave (
        output go, vec_len, hold, a_rdata, b_rdata, aff, bff,
        input  rd_en, rd_addr, a_in, b_in, awe, bwe, ais, bis, start, max_cntr, busy, done
    );
endinterface

// File: rtl/pe_feeder.sv
// Streams K A/B operand pairs from two lock-stepped memories into the PE FIFOs via a 2-entry skid.
// Define PE_FEEDER_ZPAD_EN to append one all-zero A/B pair after the K-th pair of every job.
module pe_feeder #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic         clk,
    input  logic         rst,
    pe_feeder_if.master  bus
);
    typedef enum logic [1:0] {IDLE, START, FEED, DONE} state_t;

    state_t          state_reg, state_next;
    logic [AW-1:0]   len_reg;
    logic [AW-1:0]   max_cntr_reg;
    logic [AW-1:0]   issued_reg;
    logic [AW-1:0]   written_reg;
    logic            inflight_reg;
    logic [1:0]      occ_reg, occ_next;
    logic            wr_ptr_reg;
    logic            rd_ptr_reg;
    logic [2*DW-1:0] skid_reg [2];
    logic [1:0]      load;

    logic            accept;
    logic            stall;
    logic            pop;
    logic            write;
    logic            last_write;
    logic            rd_fire;
    logic [2:0]      fill;

    always_comb begin
        accept = (state_reg == IDLE) && bus.go;
        stall  = bus.aff | bus.bff | bus.hold;
        pop    = (state_reg == FEED) && (occ_reg != 2'd0) && !stall;
`ifdef PE_FEEDER_ZPAD_EN
        // Once all K pairs are out, the pad pair is written under the same stall rules.
        write      = pop | ((state_reg == FEED) && (written_reg == len_reg) && !stall);
        last_write = (state_reg == FEED) && (written_reg == len_reg) && !stall;
`else
        write      = pop;
        last_write = pop && (written_reg == len_reg - AW'(1));
`endif
        // Slots already spoken for once this cycle's pop leaves: stored plus still-returning reads.
        fill     = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
        rd_fire  = (state_reg == FEED) && (issued_reg != len_reg) && !bus.hold && (fill < 3'd2);
        occ_next = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = (bus.vec_len == '0) ? DONE : START;
            START:   state_next = FEED;
            FEED:    if (last_write) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            len_reg      <= '0;
            max_cntr_reg <= '0;
            issued_reg   <= '0;
            written_reg  <= '0;
            inflight_reg <= 1'b0;
            occ_reg      <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= rd_fire;
            occ_reg      <= occ_next;
            if (accept) begin
                len_reg      <= bus.vec_len;
                max_cntr_reg <= (bus.vec_len == '0) ? '0 : bus.vec_len - AW'(1);
                issued_reg   <= '0;
                written_reg  <= '0;
            end else begin
                if (rd_fire) issued_reg <= issued_reg + AW'(1);
                if (pop)     written_reg <= written_reg + AW'(1);
            end
            if (inflight_reg) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)          rd_ptr_reg <= ~rd_ptr_reg;
        end
    end

    // Returning memory data is always captured, even under hold; rd_fire throttling keeps a slot free.
    for (genvar gi = 0; gi < 2; gi++) begin : g_load
        assign load[gi] = inflight_reg && (wr_ptr_reg == 1'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (load[i]) skid_reg[i] <= {bus.a_rdata, bus.b_rdata};
        end
    end

    always_comb begin
        bus.rd_en    = rd_fire;
        bus.rd_addr  = issued_reg;
        bus.awe      = write;
        bus.bwe      = write;
        bus.a_in     = pop ? skid_reg[rd_ptr_reg][2*DW-1:DW] : '0;
        bus.b_in     = pop ? skid_reg[rd_ptr_reg][DW-1:0]    : '0;
        bus.busy     = (state_reg == START) || (state_reg == FEED);
        bus.ais      = bus.busy && bus.hold;
        bus.bis      = bus.busy && bus.hold;
        bus.start    = (state_reg == START);
        bus.done     = (state_reg == DONE);
        bus.max_cntr = max_cntr_reg;
    end
endmodule
